// File: rtl/mag_display_pkg.sv
// Shared types, constants and segment lookup for the mag_display back end.
package mag_display_pkg;

    localparam int unsigned MAG_W = 6;
    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned AN_W  = 3;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned ITERS = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DIG_ONES = 2'd0,
        DIG_TENS = 2'd1,
        DIG_SIGN = 2'd2
    } dig_e;

    // Double-dabble working register: {tens, ones, remaining binary bits}
    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        logic [MAG_W-1:0] bin;
    } dd_t;

    localparam int unsigned DD_W = $bits(dd_t);

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;

    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
module seg_decode
    import mag_display_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = bcd_to_seg(bcd);

endmodule

// File: rtl/mag_display.sv
// Captures a sign/magnitude pair, converts it to BCD by double-dabble and
// scans sign/tens/ones onto a 3-digit display. Option: MAG_DISPLAY_LZB_EN.
module mag_display
    import mag_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [MAG_W-1:0] MAG_RESULT,
    input  logic             NEG_FLAG,
    input  logic             LOAD,
    output logic             BUSY,
    output logic [SEG_W-1:0] SEG,
    output logic [AN_W-1:0]  AN
);

    localparam int unsigned RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_e           state_q, state_d;
    dd_t              dd_q, dd_d, dd_work;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             neg_pending_q, neg_pending_d;
    logic [BCD_W-1:0] tens_disp_q, tens_disp_d;
    logic [BCD_W-1:0] ones_disp_q, ones_disp_d;
    logic             sign_disp_q, sign_disp_d;
    logic             busy_q, busy_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    dig_e             dsel_q, dsel_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [AN_W-1:0]  an_q, an_d;
    logic [BCD_W-1:0] dig_c;
    logic [SEG_W-1:0] dec_seg_c;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            dd_q          <= '0;
            bit_cnt_q     <= '0;
            neg_pending_q <= 1'b0;
            tens_disp_q   <= '0;
            ones_disp_q   <= '0;
            sign_disp_q   <= 1'b0;
            busy_q        <= 1'b0;
            rc_q          <= '0;
            dsel_q        <= DIG_ONES;
            seg_q         <= SEG_BLANK;
            an_q          <= '1;
        end else begin
            state_q       <= state_d;
            dd_q          <= dd_d;
            bit_cnt_q     <= bit_cnt_d;
            neg_pending_q <= neg_pending_d;
            tens_disp_q   <= tens_disp_d;
            ones_disp_q   <= ones_disp_d;
            sign_disp_q   <= sign_disp_d;
            busy_q        <= busy_d;
            rc_q          <= rc_d;
            dsel_q        <= dsel_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    // Conversion FSM: capture, six add-3/shift iterations, then commit
    always_comb begin
        state_d       = state_q;
        dd_d          = dd_q;
        dd_work       = dd_q;
        bit_cnt_d     = bit_cnt_q;
        neg_pending_d = neg_pending_q;
        tens_disp_d   = tens_disp_q;
        ones_disp_d   = ones_disp_q;
        sign_disp_d   = sign_disp_q;
        case (state_q)
            ST_IDLE: begin
                if (LOAD) begin
                    state_d       = ST_SHIFT;
                    dd_d          = '{tens: '0, ones: '0, bin: MAG_RESULT};
                    neg_pending_d = NEG_FLAG;
                    bit_cnt_d     = '0;
                end
            end
            ST_SHIFT: begin
                if (dd_work.tens >= BCD_W'(5)) dd_work.tens = dd_work.tens + BCD_W'(3);
                if (dd_work.ones >= BCD_W'(5)) dd_work.ones = dd_work.ones + BCD_W'(3);
                dd_d      = dd_t'(DD_W'(dd_work) << 1);
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(ITERS - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                tens_disp_d = dd_q.tens;
                ones_disp_d = dd_q.ones;
                sign_disp_d = neg_pending_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Free-running refresh counter and digit select
    always_comb begin
        rc_d   = rc_q + RC_W'(1);
        dsel_d = dsel_q;
        if (rc_q == RC_W'(REFRESH_DIV - 1)) begin
            rc_d = '0;
            case (dsel_q)
                DIG_ONES: dsel_d = DIG_TENS;
                DIG_TENS: dsel_d = DIG_SIGN;
                default:  dsel_d = DIG_ONES;
            endcase
        end
    end

    always_comb begin
        dig_c = ones_disp_q;
        if (dsel_q == DIG_TENS) dig_c = tens_disp_q;
    end

    seg_decode u_seg_decode (
        .bcd   (dig_c),
        .seg_c (dec_seg_c)
    );

    always_comb begin
        seg_d = dec_seg_c;
        an_d  = 3'b110;
        case (dsel_q)
            DIG_TENS: begin
                an_d = 3'b101;
`ifdef MAG_DISPLAY_LZB_EN
                if (tens_disp_q == '0) seg_d = SEG_BLANK;
`endif
            end
            DIG_SIGN: begin
                an_d  = 3'b011;
                seg_d = sign_disp_q ? SEG_MINUS : SEG_BLANK;
            end
            default: ;
        endcase
    end

    assign BUSY = busy_q;
    assign SEG  = seg_q;
    assign AN   = an_q;

endmodule

// File: tb/tb_mag_display.sv
// Scoreboard bench for mag_display with REFRESH_DIV=4.
module tb_mag_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] MIN = 7'b0111111;
`ifdef MAG_DISPLAY_LZB_EN
    localparam logic [6:0] T0 = BLK;
`else
    localparam logic [6:0] T0 = S0;
`endif

    typedef struct {
        int unsigned busy_len;
        logic [6:0]  sgn;
        logic [6:0]  tens;
        logic [6:0]  ones;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [5:0] MAG_RESULT = '0;
    logic       NEG_FLAG = 1'b0;
    logic       LOAD = 1'b0;
    logic       BUSY;
    logic [6:0] SEG;
    logic [2:0] AN;

    int   checks = 0;
    int   errors = 0;
    int   txn_done = 0;
    exp_t exp_q[$];

    mag_display #(.REFRESH_DIV(4)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .MAG_RESULT (MAG_RESULT),
        .NEG_FLAG   (NEG_FLAG),
        .LOAD       (LOAD),
        .BUSY       (BUSY),
        .SEG        (SEG),
        .AN         (AN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: measures each BUSY pulse, then checks one full scan of the display
    int          mode = 0;
    int unsigned busy_cnt = 0;
    int          samp = 0;
    logic [2:0]  seen = '0;
    exp_t        cur;

    always @(negedge CLK) begin
        if (!RST_N) begin
            mode = 0;
            busy_cnt = 0;
        end else begin
            case (mode)
                0: if (BUSY) begin busy_cnt = 1; mode = 1; end
                1: begin
                    if (BUSY) begin
                        busy_cnt++;
                        if (busy_cnt > 40) begin
                            chk("busy_timeout", 7'd1, 7'd0);
                            mode = 0;
                            txn_done++;
                        end
                    end else if (exp_q.size() == 0) begin
                        chk("unexpected_conversion", 7'd1, 7'd0);
                        mode = 0;
                    end else begin
                        cur = exp_q.pop_front();
                        chk("busy_len", 7'(busy_cnt), 7'(cur.busy_len));
                        samp = 0;
                        seen = '0;
                        mode = 2;
                    end
                end
                default: begin
                    case (AN)
                        3'b110:  begin chk("ones", SEG, cur.ones); seen[0] = 1'b1; end
                        3'b101:  begin chk("tens", SEG, cur.tens); seen[1] = 1'b1; end
                        3'b011:  begin chk("sign", SEG, cur.sgn);  seen[2] = 1'b1; end
                        default: chk("an_onehot", {4'b0, AN}, 7'b0000110);
                    endcase
                    samp++;
                    if (samp == 12) begin
                        chk("scan_coverage", {4'b0, seen}, 7'b0000111);
                        txn_done++;
                        mode = 0;
                    end
                end
            endcase
        end
    end

    task automatic do_load(input logic [5:0] m, input logic n);
        MAG_RESULT = m;
        NEG_FLAG   = n;
        LOAD       = 1'b1;
        @(negedge CLK);
        LOAD       = 1'b0;
    endtask

    task automatic push(input logic [6:0] s, input logic [6:0] t, input logic [6:0] o);
        exp_t e;
        e.busy_len = 7;
        e.sgn  = s;
        e.tens = t;
        e.ones = o;
        exp_q.push_back(e);
    endtask

    task automatic wait_txn(input int target);
        for (int i = 0; i < 200 && txn_done < target; i++) @(negedge CLK);
        chk("txn_complete", 7'(txn_done >= target), 7'd1);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_seg", SEG, BLK);
        chk("rst_an", {4'b0, AN}, 7'b0000111);
        chk("rst_busy", {6'b0, BUSY}, 7'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("first_an", {4'b0, AN}, 7'b0000110);
        chk("first_seg", SEG, S0);
        repeat (2) @(negedge CLK);

        push(MIN, S3, S7);
        do_load(6'd37, 1'b1);
        wait_txn(1);

        push(BLK, S6, S3);
        do_load(6'd63, 1'b0);
        wait_txn(2);

`ifdef MAG_DISPLAY_LZB_EN
        push(BLK, BLK, S5);
`else
        push(BLK, S0, S5);
`endif
        do_load(6'd5, 1'b0);
        wait_txn(3);

        push(MIN, T0, S0);
        do_load(6'd0, 1'b1);
        wait_txn(4);

        // Loads during SHIFT and during DONE must both be dropped
        push(BLK, S1, S2);
        do_load(6'd12, 1'b0);
        repeat (2) @(negedge CLK);
        do_load(6'd9, 1'b0);
        repeat (3) @(negedge CLK);
        do_load(6'd9, 1'b0);
        wait_txn(5);
        repeat (4) @(negedge CLK);
        chk("queue_empty", 7'(exp_q.size()), 7'd0);

        // Abort mid-conversion with reset
        do_load(6'd20, 1'b0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("abort_busy", {6'b0, BUSY}, 7'd0);
        chk("abort_seg", SEG, BLK);
        chk("abort_an", {4'b0, AN}, 7'b0000111);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            checks++;
            if (SEG === S2) begin
                errors++;
                $display("FAIL no_two: got %b at %0t", SEG, $time);
            end
            chk("post_abort_busy", {6'b0, BUSY}, 7'd0);
            case (AN)
                3'b110:  chk("post_abort_ones", SEG, S0);
                3'b101:  chk("post_abort_tens", SEG, T0);
                3'b011:  chk("post_abort_sign", SEG, BLK);
                default: chk("post_abort_an", {4'b0, AN}, 7'b0000110);
            endcase
        end
        chk("final_queue_empty", 7'(exp_q.size()), 7'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/mag_display.md
# mag_display

Sequential display back end for the ALU datapath. It captures the 6-bit magnitude and sign flag produced by the magnitude stage and converts the magnitude to two BCD digits with a shift-add-3 (double-dabble) state machine, one bit per cycle. It then time-multiplexes sign, tens and ones onto a 3-digit common-anode seven-segment display.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; legal range ≥ 2.
- `CLK`  in  1: single clock; all state on its rising edge.
- `RST_N`  in  1: asynchronous active-low reset; assertion is asynchronous, release is synchronous to `CLK`.
- `MAG_RESULT`  in  6: unsigned magnitude, 0–63.
- `NEG_FLAG`  in  1: sign of the value; 1 = negative.
- `LOAD`  in  1: 1-cycle request to capture `MAG_RESULT` and `NEG_FLAG`.
- `BUSY`  out  1: conversion in progress.
- `SEG`  out  7: segments {g,f,e,d,c,b,a}, active-low.
- `AN`  out  3: digit enables, active-low. [2] = sign, [1] = tens, [0] = ones.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
  - IDLE → SHIFT on `LOAD`=1. `MAG_RESULT` goes into the shift register and `NEG_FLAG` into `neg_pending`; the bit counter is cleared.
  - SHIFT runs 6 iterations. In each iteration, any BCD nibble ≥ 5 gets +3, then {tens,ones,bin} shifts left by 1.
  - SHIFT → DONE when iteration 6 completes.
  - DONE copies the tens/ones nibbles and `neg_pending` into the display registers, then returns to IDLE.
- `LOAD` while `BUSY`=1 is ignored. There is no queueing.
- The display keeps showing the previous value until DONE commits. No partial results ever reach the display.
- The tens digit ranges 0–6 and the ones digit 0–9. No other codes are reachable.
- The scanner runs independently of the FSM:
  - The refresh counter counts 0..`REFRESH_DIV`-1 and wraps.
  - On each wrap, digit select advances 0 → 1 → 2 → 0.
- Per-digit content:
  - Sign digit: '-' (`SEG`=0111111) when the stored sign is 1, otherwise blank (1111111).
  - Tens digit: BCD decode.
  - Ones digit: BCD decode, always lit.
- Negative zero (`NEG_FLAG`=1, `MAG_RESULT`=0) is displayed as captured: "-0" (sign lit).
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

## Timing
- Reset values:
  - `BUSY`=0, `SEG`=1111111, `AN`=111.
  - Display registers = 0, sign = 0, digit select = 0, refresh counter = 0, FSM in IDLE.
- `LOAD` sampled high at edge N: `BUSY`=1 from edge N through edge N+6, and `BUSY`=0 after edge N+7.
- The new value is visible on `SEG` for the currently selected digit after edge N+8. This is 8-cycle latency.
- `SEG` and `AN` are registered. They reflect digit select and the display registers one cycle after either changes.
- Exactly one `AN` bit is low at any time after the first post-reset edge. The first post-reset edge selects ones.
- `LOAD` in the same cycle as DONE is ignored. It is accepted only when the FSM is in IDLE.
- `RST_N` asserted mid-conversion aborts the conversion immediately. Nothing is committed and all registers return to their reset values.

## Configuration
- `MAG_DISPLAY_LZB_EN` enables leading-zero blanking.
  - Defined: the tens digit is blank (1111111) when tens = 0.
  - Undefined: the tens digit always shows its decoded value, including '0'.

## Structure
- Package `mag_display_pkg` holds:
  - the FSM state enum;
  - the segment constants `SEG_BLANK` and `SEG_MINUS`;
  - the digit-to-segment lookup function.
- Sub-module `seg_decode` is purely combinational: 4-bit BCD in, 7-bit active-low segment pattern out. It is instantiated once on the muxed digit.
- The top module contains the FSM, the double-dabble datapath, the refresh counter and the output registers.

## Test plan
All scenarios use `REFRESH_DIV`=4.

- **Reset values:** reset, then release → `SEG`=1111111 and `AN`=111 during reset. First edge after release: `AN`=110, `SEG`=1000000 (ones '0').
- **Negative value:** `LOAD` with `MAG_RESULT`=37, `NEG_FLAG`=1 → `BUSY` high for 7 cycles. After the scan, the sign digit shows 0111111, tens 0110000 ('3'), ones 1111000 ('7').
- **Maximum value:** `LOAD` with `MAG_RESULT`=63, `NEG_FLAG`=0 → sign blank, tens 0000010 ('6'), ones 0110000 ('3').
- **Leading-zero blanking:** `LOAD` with `MAG_RESULT`=5 → tens 1111111 with `MAG_DISPLAY_LZB_EN` defined, 1000000 without it. Ones is 0010010 in both builds.
- **Busy and DONE rejection:** second `LOAD` (value 9) asserted 3 cycles after a first `LOAD` of 12, then again in the DONE cycle → both ignored; the display settles to "12".
- **Reset mid-conversion:** `RST_N` pulsed low 3 cycles after `LOAD` of 20 → `BUSY`=0 immediately, the display shows the reset "0", and no '2' ever appears.
